// File: rtl/alimentador_promedio.sv
// Feeder for the windowed averager: buffers raw samples in a small FIFO and
// emits one clear strobe, 14 data strobes and one finalize strobe per window.
module alimentador_promedio #(
    parameter int N     = 4,
    parameter int DEPTH = 4,
    parameter int HOLD  = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         habilitar,
    input  logic [N-1:0]                 samp_in,
    input  logic                         samp_valid,
    output logic                         samp_ready,
    output logic                         en_out,
    output logic [N-1:0]                 dato_out,
    output logic                         resultado_valido,
    output logic                         ventana_fin,
    output logic [$clog2(DEPTH+1)-1:0]   nivel
);

    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW    = $clog2(DEPTH + 1);
    localparam int HW    = $clog2(HOLD + 1);
    localparam int DATOS = 14;

    localparam logic [LW-1:0] LLENO     = LW'(DEPTH);
    localparam logic [3:0]    ULTIMO    = 4'(DATOS);
    localparam logic [HW-1:0] HOLD_INI  = HW'(HOLD);
    localparam logic [HW-1:0] HOLD_FIN  = HW'(1);

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        DATA,
        FIN,
        ESPERA
    } estado_t;

    estado_t estado, estado_sig;

    logic [N-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [3:0]    cuenta;
    logic [HW-1:0] espera_cnt;
    logic          push, pop;
    logic          en_d, vf_d, rv_d;
    logic [N-1:0]  dato_d;

    // Readiness comes from current occupancy only, so a full FIFO never
    // accepts even on a cycle where it also pops.
    assign samp_ready = (nivel != LLENO);
    assign push       = samp_valid && samp_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado           <= IDLE;
            en_out           <= 1'b0;
            dato_out         <= '0;
            resultado_valido <= 1'b0;
            ventana_fin      <= 1'b0;
        end else begin
            estado           <= estado_sig;
            en_out           <= en_d;
            dato_out         <= dato_d;
            resultado_valido <= rv_d;
            ventana_fin      <= vf_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            nivel      <= '0;
            cuenta     <= '0;
            espera_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   nivel <= nivel + 1'b1;
                2'b01:   nivel <= nivel - 1'b1;
                default: nivel <= nivel;
            endcase

            if (estado == CLR) begin
                cuenta <= '0;
            end else if (pop) begin
                cuenta <= cuenta + 1'b1;
            end

            if (estado == FIN) begin
                espera_cnt <= HOLD_INI;
            end else if (estado == ESPERA && espera_cnt != '0) begin
                espera_cnt <= espera_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= samp_in;
        end
    end

    // DATA stays put until the counter shows 14 emitted pops; the following
    // edge always goes to FIN, independent of FIFO occupancy.
    always_comb begin
        estado_sig = estado;
        pop        = 1'b0;
        case (estado)
            IDLE: begin
                if (habilitar) begin
                    estado_sig = CLR;
                end
            end
            CLR: begin
                estado_sig = DATA;
            end
            DATA: begin
                if (cuenta == ULTIMO) begin
                    estado_sig = FIN;
                end else if (nivel != '0) begin
                    pop = 1'b1;
                end
            end
            FIN: begin
                estado_sig = ESPERA;
            end
            ESPERA: begin
                if (espera_cnt == HOLD_FIN) begin
                    estado_sig = habilitar ? CLR : IDLE;
                end
            end
            default: begin
                estado_sig = IDLE;
            end
        endcase
    end

    // Registered outputs describe the state being entered on this edge.
    always_comb begin
        en_d   = (estado_sig == CLR) || (estado_sig == FIN) || pop;
        dato_d = pop ? mem[rd_ptr] : '0;
        vf_d   = (estado_sig == FIN);
        rv_d   = (estado_sig == ESPERA);
    end

endmodule

// File: doc/alimentador_promedio.md
Name: alimentador_promedio

Overview:
- Upstream feeder for the windowed averager. Accepts raw N-bit samples over a valid/ready handshake and buffers them in a small FIFO.
- Emits the averager's `en` strobe and data in a fixed 16-strobe window:
  - 1 clear strobe;
  - 14 data strobes;
  - 1 finalize strobe, issued back-to-back after the 14th data strobe.
- After each window it holds the result-valid indication for HOLD cycles.

Parameters:
- N, 4: sample / data width.
- DEPTH, 4: FIFO depth in entries; must be a power of two and at least 2.
- HOLD, 2: cycles `resultado_valido` stays high after the finalize strobe; must be at least 1.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- habilitar  input  1  run enable; sampled in IDLE and at the end of ESPERA.
- samp_in  input  N  raw sample.
- samp_valid  input  1  samp_in is valid.
- samp_ready  output  1  FIFO can accept; equals !full (combinational from occupancy).
- en_out  output  1  strobe to the averager's `en`.
- dato_out  output  N  data to the averager's `in`; 0 on non-data strobes and when en_out=0.
- resultado_valido  output  1  averager output is stable and readable.
- ventana_fin  output  1  one-cycle pulse coincident with the finalize strobe.
- nivel  output  clog2(DEPTH+1)  FIFO occupancy.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE; FIFO is emptied (nivel=0, pointers=0); data counter=0; hold counter=0.
  - Outputs: en_out=0, dato_out=0, resultado_valido=0, ventana_fin=0, samp_ready=1.
- Outputs are registered: en_out, dato_out, resultado_valido and ventana_fin are updated on the edge that enters or advances a state.
- FIFO rules:
  - Push when samp_valid && samp_ready.
  - Pop only in DATA when nivel>0.
  - Push and pop in the same cycle is allowed when not full; nivel is then unchanged.
  - When full, no push occurs even if a pop happens that cycle, because samp_ready=0 is decided from current occupancy.
  - No bypass: a sample accepted at edge k is emitted no earlier than edge k+1.
  - Pointers wrap modulo DEPTH.
- FSM states:
  - IDLE: en_out=0. If habilitar=1, go to CLR.
  - CLR: one cycle with en_out=1, dato_out=0. Reset the data counter to 0. Go to DATA.
  - DATA:
    - If nivel>0: pop, en_out=1, dato_out=head, counter+1.
    - If nivel=0: en_out=0 and the FSM waits (gaps are allowed).
    - When the 14th pop is emitted, go to FIN.
    - habilitar is ignored mid-window; a window always completes.
  - FIN: exactly the cycle after the 14th data strobe. en_out=1, dato_out=0, ventana_fin=1. Load the hold counter with HOLD. Go to ESPERA.
    - The FIFO does not pop here, even if nonempty.
  - ESPERA: en_out=0, resultado_valido=1. Decrement the hold counter each cycle.
    - At expiry: go to CLR if habilitar=1, else to IDLE.
    - resultado_valido falls on the same edge.
- Window invariant: exactly 16 en_out strobes per window, and exactly 14 of them carry FIFO data.
  - The data strobes carry samples in FIFO (arrival) order.
  - FIN always immediately follows the 14th data strobe; it is never delayed by FIFO state.
- Input acceptance continues in every state except reset, including IDLE and ESPERA, until full.
- Reset mid-window: the window is abandoned, buffered samples are discarded, and the block restarts from IDLE.

Test Plan:
1. Reset low for 3 cycles, then release with habilitar=0 → en_out=0, samp_ready=1, nivel=0, all outputs 0.
2. Continuous samp_valid with values 1..14 and habilitar=1 → en_out sequence is CLR(0), then 1..14 in order, then FIN(0) with ventana_fin=1. resultado_valido is high for exactly 2 cycles.
3. Samples fed with 2-cycle gaps → en_out has gaps during DATA. Still exactly 14 data strobes, and FIN is the very next cycle after data 14.
4. Push 5 samples while in IDLE with DEPTH=4 → the first 4 are accepted, samp_ready=0 when nivel=4, and the 5th is held (not lost) until a pop.
5. Simultaneous push/pop at nivel=2 → nivel stays 2, and data order is preserved across a pointer wrap (20 samples streamed).
6. Assert reset at data strobe 7, then release → en_out=0 and nivel=0 immediately. The next window starts with CLR and uses only newly accepted samples.
